// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner and the matching digit-scan driver.
//   - scan_state_t : scanner FSM encodings (SCAN / DEBOUNCE / HELD, 2 bits)
//   - ROW_IDLE     : all rows released
//   - ROW_TABLE    : one-cold row drive pattern indexed by row number
//   - classify_cols: sorts a synchronised active-low column word into
//                    none / single / multi and returns the single column index
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } scan_state_t;

    typedef enum logic [1:0] {
        COL_NONE   = 2'd0,
        COL_SINGLE = 2'd1,
        COL_MULTI  = 2'd2
    } col_class_t;

    typedef struct packed {
        col_class_t cls;
        logic [1:0] idx;
    } col_info_t;

    localparam logic [3:0] ROW_IDLE = 4'b1111;

    // Element n drives row n low: [0]=1110, [1]=1101, [2]=1011, [3]=0111.
    localparam logic [3:0][3:0] ROW_TABLE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    function automatic col_info_t classify_cols(input logic [3:0] cols);
        col_info_t  info;
        logic [2:0] lows;
        info.cls = COL_NONE;
        info.idx = 2'd0;
        lows     = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (!cols[i]) begin
                lows     = lows + 3'd1;
                info.idx = 2'(i);
            end
        end
        if (lows == 3'd1) begin
            info.cls = COL_SINGLE;
        end else if (lows != 3'd0) begin
            info.cls = COL_MULTI;
        end
        return info;
    endfunction

endpackage

// File: rtl/keypad_scanner_scan_tick_gen.sv
// Scan-rate prescaler shared by the keypad scanner and the display multiplexer.
//   clk  in  system clock
//   rst  in  asynchronous reset, active-low
//   tick out one-clk strobe while the prescaler sits at DIV-1; it then wraps to 0
module scan_tick_gen #(
    parameter int DIV = 131072
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count_reg;

    assign tick = (count_reg == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad reader: drives one active-low row per scan slot, samples the
// active-low columns at the end of the slot, debounces presses and releases, and
// reports one hex code per press over a valid/ack handshake.
//   clk       in   system clock
//   rst       in   asynchronous reset, active-low
//   col_in    in   [3:0] keypad columns, active-low, asynchronous
//   key_ack   in   consumer acknowledge (pulse or level)
//   row_sel   out  [3:0] one-cold row drive
//   key_code  out  [3:0] {row, col} of the last accepted key
//   key_valid out  new key available; cleared on the clk after key_ack
//   key_held  out  accepted key still physically down
//   overrun   out  sticky: a key was accepted while key_valid was still set
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV       = 131072,
    parameter int DEBOUNCE_SCANS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    input  logic       key_ack,
    output logic [3:0] row_sel,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       overrun
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_SCANS - 1);

    logic        tick;
    logic [3:0]  col_meta_reg;
    logic [3:0]  col_sync_reg;
    col_info_t   col_info;

    scan_state_t state_reg,     state_next;
    logic [1:0]  row_idx_reg,   row_idx_next;
    logic [1:0]  col_idx_reg,   col_idx_next;
    logic [7:0]  cnt_reg,       cnt_next;
    logic [3:0]  key_code_reg,  key_code_next;
    logic        key_valid_reg, key_valid_next;
    logic        overrun_reg,   overrun_next;
    logic        accept;

    scan_tick_gen #(
        .DIV (SCAN_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchroniser per column line; idle (pulled-up) value on reset.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col_sync
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    col_meta_reg[gi] <= ROW_IDLE[gi];
                    col_sync_reg[gi] <= ROW_IDLE[gi];
                end else begin
                    col_meta_reg[gi] <= col_in[gi];
                    col_sync_reg[gi] <= col_meta_reg[gi];
                end
            end
        end
    endgenerate

    assign col_info = classify_cols(col_sync_reg);

    // State register (FSM state plus its datapath and handshake registers).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_SCAN;
            row_idx_reg   <= 2'd0;
            col_idx_reg   <= 2'd0;
            cnt_reg       <= 8'd0;
            key_code_reg  <= 4'd0;
            key_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            row_idx_reg   <= row_idx_next;
            col_idx_reg   <= col_idx_next;
            cnt_reg       <= cnt_next;
            key_code_reg  <= key_code_next;
            key_valid_reg <= key_valid_next;
            overrun_reg   <= overrun_next;
        end
    end

    // Next-state logic. The tick marks the end of a row slot, so the synced
    // columns seen on a tick belong to the row that was driven for that slot.
    // cnt_reg is the press count in DEBOUNCE and the release count in HELD.
    always_comb begin
        state_next   = state_reg;
        row_idx_next = row_idx_reg;
        col_idx_next = col_idx_reg;
        cnt_next     = cnt_reg;
        accept       = 1'b0;
        if (tick) begin
            case (state_reg)
                ST_SCAN: begin
                    if (col_info.cls == COL_SINGLE) begin
                        col_idx_next = col_info.idx;
                        cnt_next     = 8'd1;
                        state_next   = ST_DEBOUNCE;
                    end else begin
                        row_idx_next = row_idx_reg + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (col_info.cls == COL_SINGLE && col_info.idx == col_idx_reg) begin
                        if (cnt_reg == CNT_LAST) begin
                            accept     = 1'b1;
                            cnt_next   = 8'd0;
                            state_next = ST_HELD;
                        end else begin
                            cnt_next = cnt_reg + 8'd1;
                        end
                    end else begin
                        cnt_next     = 8'd0;
                        state_next   = ST_SCAN;
                        row_idx_next = row_idx_reg + 2'd1;
                    end
                end
                ST_HELD: begin
                    if (col_info.cls == COL_NONE) begin
                        if (cnt_reg == CNT_LAST) begin
                            cnt_next     = 8'd0;
                            state_next   = ST_SCAN;
                            row_idx_next = row_idx_reg + 2'd1;
                        end else begin
                            cnt_next = cnt_reg + 8'd1;
                        end
                    end else begin
                        cnt_next = 8'd0;
                    end
                end
                default: begin
                    cnt_next   = 8'd0;
                    state_next = ST_SCAN;
                end
            endcase
        end
    end

    // Handshake. An accept wins over a simultaneous ack: the consumer acked the
    // old code, so the new one is valid and nothing was lost (overrun clear).
    always_comb begin
        key_code_next  = key_code_reg;
        key_valid_next = key_valid_reg;
        overrun_next   = overrun_reg;
        if (accept) begin
            key_code_next  = {row_idx_reg, col_idx_reg};
            key_valid_next = 1'b1;
            overrun_next   = key_valid_reg & ~key_ack;
        end else if (key_ack && key_valid_reg) begin
            key_valid_next = 1'b0;
            overrun_next   = 1'b0;
        end
    end

    // Outputs.
    always_comb begin
        row_sel   = ROW_IDLE;
        row_sel   = ROW_TABLE[row_idx_reg];
        key_held  = (state_reg == ST_HELD);
        key_code  = key_code_reg;
        key_valid = key_valid_reg;
        overrun   = overrun_reg;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 8;
    localparam int DEBOUNCE_SCANS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col_in;
    logic       key_ack = 1'b0;
    logic [3:0] row_sel;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       overrun;

    // Keypad model: the pressed key pulls its column pattern onto col_in only
    // while its own row is being driven.
    logic       model_en  = 1'b0;
    logic [1:0] model_row = 2'd0;
    logic [3:0] model_pat = 4'hF;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [3:0] bench_row(input int idx);
        case (idx)
            0:       bench_row = 4'b1110;
            1:       bench_row = 4'b1101;
            2:       bench_row = 4'b1011;
            default: bench_row = 4'b0111;
        endcase
    endfunction

    assign col_in = (model_en && row_sel == bench_row(int'(model_row))) ? model_pat : 4'hF;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_in    (col_in),
        .key_ack   (key_ack),
        .row_sel   (row_sel),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // 0: key_valid, 1: key released (!key_held), 2: overrun, 3..6: row_sel == row (sel-3)
    function automatic logic probe(input int sel);
        case (sel)
            0:       probe = key_valid;
            1:       probe = !key_held;
            2:       probe = overrun;
            default: probe = (row_sel == bench_row(sel - 3));
        endcase
    endfunction

    task automatic wait_for(input int sel, input string name);
        for (int i = 0; i < 300; i++) begin
            if (probe(sel)) return;
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL timeout_%s: got no event in 300 cycles expected event", name);
    endtask

    task automatic pulse_ack;
        @(posedge clk);
        #1 key_ack = 1'b1;
        @(posedge clk);
        #1 key_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic press(input logic [1:0] r, input logic [3:0] pat);
        model_row = r;
        model_pat = pat;
        model_en  = 1'b1;
    endtask

    // Scoreboard monitor: each new accept (valid rising, or overrun rising while
    // valid is held) consumes one expected code.
    initial begin : monitor
        logic       prev_v;
        logic       prev_o;
        logic [3:0] e;
        prev_v = 1'b0;
        prev_o = 1'b0;
        forever begin
            @(negedge clk);
            if ((key_valid && !prev_v) || (overrun && !prev_o && prev_v)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: got code %0h expected no key", key_code);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_key_code", 32'(key_code), 32'(e));
                end
            end
            prev_v = key_valid;
            prev_o = overrun;
        end
    end

    initial begin
        // Reset values
        #2 rst = 1'b0;
        #1;
        check("rst_row_sel",   32'(row_sel),   32'h E);
        check("rst_key_code",  32'(key_code),  32'h0);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_key_held",  32'(key_held),  32'h0);
        check("rst_overrun",   32'(overrun),   32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // 1: idle scan, one row per 8 clk
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            check("idle_row_sel", 32'(row_sel), 32'(bench_row((k / 8) % 4)));
        end
        check("idle_key_valid", 32'(key_valid), 32'h0);

        // 2: key 6 (row1, col2), stable from the start of a row1 slot
        wait_for(3, "row0");
        press(2'd1, 4'b1011);
        exp_q.push_back(4'h6);
        wait_for(4, "row1");
        repeat (DEBOUNCE_SCANS * SCAN_DIV - 1) @(negedge clk);
        check("lat_before", 32'(key_valid), 32'h0);
        @(negedge clk);
        check("lat_valid", 32'(key_valid), 32'h1);
        check("p6_held",   32'(key_held),  32'h1);
        check("p6_frozen", 32'(row_sel),   32'(bench_row(1)));
        repeat (16) @(negedge clk);
        check("p6_valid_hold", 32'(key_valid), 32'h1);
        pulse_ack;
        check("p6_ack_clear", 32'(key_valid), 32'h0);
        check("p6_still_held", 32'(key_held), 32'h1);

        // 3: release -> back to scanning at row2
        model_en = 1'b0;
        wait_for(1, "release6");
        check("rel_row2", 32'(row_sel), 32'(bench_row(2)));

        // 4: bounce on key 6: two good slots, one open slot, then stable
        press(2'd1, 4'b1011);
        wait_for(4, "row1_bounce");
        repeat (2 * SCAN_DIV) @(negedge clk);
        model_pat = 4'hF;
        repeat (SCAN_DIV) @(negedge clk);
        check("bounce_no_valid", 32'(key_valid), 32'h0);
        check("bounce_row2",     32'(row_sel),   32'(bench_row(2)));
        model_pat = 4'b1011;
        exp_q.push_back(4'h6);
        wait_for(0, "bounce_accept");
        pulse_ack;
        model_en = 1'b0;
        wait_for(1, "release_bounce");

        // multi-column pattern is never accepted
        press(2'd1, 4'b0011);
        repeat (100) @(negedge clk);
        check("multi_no_valid", 32'(key_valid), 32'h0);
        check("multi_no_held",  32'(key_held),  32'h0);
        model_en = 1'b0;
        repeat (8) @(negedge clk);

        // 5: accept 6 without ack, then F -> overrun
        press(2'd1, 4'b1011);
        exp_q.push_back(4'h6);
        wait_for(0, "ovr_first");
        model_en = 1'b0;
        wait_for(1, "ovr_release6");
        press(2'd3, 4'b0111);
        exp_q.push_back(4'hF);
        wait_for(2, "ovr_set");
        check("ovr_flag",  32'(overrun),   32'h1);
        check("ovr_valid", 32'(key_valid), 32'h1);
        check("ovr_code",  32'(key_code),  32'hF);
        pulse_ack;
        check("ovr_ack_valid",   32'(key_valid), 32'h0);
        check("ovr_ack_overrun", 32'(overrun),   32'h0);
        model_en = 1'b0;
        wait_for(1, "ovr_releaseF");

        // 6: reset while debouncing (count=2)
        wait_for(3, "row0_rst");
        press(2'd1, 4'b1011);
        wait_for(4, "row1_rst");
        repeat (2 * SCAN_DIV + 2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_row_sel",   32'(row_sel),   32'h E);
        check("mid_rst_key_code",  32'(key_code),  32'h0);
        check("mid_rst_key_valid", 32'(key_valid), 32'h0);
        check("mid_rst_key_held",  32'(key_held),  32'h0);
        check("mid_rst_overrun",   32'(overrun),   32'h0);
        model_en = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (100) @(negedge clk);
        check("post_rst_no_valid", 32'(key_valid), 32'h0);
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
